// File: rtl/vector_division_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_v_pkg / vector_division_arbiter
//
// Purpose:
//   Two-requester front end for a fixed-latency vector division datapath.
//   Requests are arbitrated round-robin. An operation is accepted only while a
//   response FIFO slot is guaranteed for it. Results are buffered and returned
//   in acceptance order with the id of the originating requester.
//
// Ports:
//   clock, reset                     single clock, synchronous active-high reset
//   req0_* / req1_*                  valid/ready request channels with control
//                                    (execution_vector) and operands vs2, vs1
//   div_issue, div_execution_vector,
//   div_vs2, div_vs1                 operation presented to the datapath
//   div_vd                           datapath result, DIV_LATENCY cycles later
//   rsp_valid, rsp_ready,
//   rsp_id, rsp_vd                   response channel (FIFO head)
//   busy                             operation in flight or response buffered
// -----------------------------------------------------------------------------
package riscv_v_pkg;
  localparam int VLEN = 128;

  typedef struct packed {
    logic [2:0] funct;  // division flavour (div/divu/rem/remu)
    logic [1:0] vsew;   // element width
    logic       vm;     // mask enable
    logic [7:0] vl;     // vector length
  } execution_vector_t;
endpackage

module vector_division_arbiter
  import riscv_v_pkg::*;
#(
  parameter int DIV_LATENCY = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  execution_vector_t req0_execution_vector,
  input  logic [VLEN-1:0]   req0_vs2,
  input  logic [VLEN-1:0]   req0_vs1,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  execution_vector_t req1_execution_vector,
  input  logic [VLEN-1:0]   req1_vs2,
  input  logic [VLEN-1:0]   req1_vs1,

  output logic              div_issue,
  output execution_vector_t div_execution_vector,
  output logic [VLEN-1:0]   div_vs2,
  output logic [VLEN-1:0]   div_vs1,
  input  logic [VLEN-1:0]   div_vd,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [VLEN-1:0]   rsp_vd,

  output logic              busy
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // State
  logic                   rst_q;        // reset was asserted last cycle
  logic                   last_grant;   // id of the requester accepted last
  logic [DIV_LATENCY-1:0] stage_valid;
  logic [DIV_LATENCY-1:0] stage_id;
  logic [CNT_W-1:0]       credit_cnt;   // in-flight ops + FIFO occupancy
  logic [CNT_W-1:0]       fifo_count;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [VLEN-1:0]        mem_vd [RSP_DEPTH];
  logic                   mem_id [RSP_DEPTH];

  // Handshake terms
  logic fifo_empty;
  logic push;
  logic pop;
  logic credit_ok;
  logic accept_block;
  logic acc0;
  logic acc1;
  logic acc_id;

  assign fifo_empty = (fifo_count == '0);
  assign push       = stage_valid[DIV_LATENCY-1];
  assign pop        = rsp_valid & rsp_ready;

  // A response leaving this cycle frees its slot for a same-cycle accept.
  assign credit_ok  = (credit_cnt < CNT_W'(RSP_DEPTH)) | pop;

  // Nothing is accepted while reset is high, nor in the first cycle after it.
  assign accept_block = reset | rst_q;

  // Round-robin: with both valid, the requester not served last wins. A
  // requester's ready looks only at the other requester's valid.
  assign req0_ready = ~accept_block & credit_ok & (~req1_valid | last_grant);
  assign req1_ready = ~accept_block & credit_ok & (~req0_valid | ~last_grant);

  assign acc0      = req0_valid & req0_ready;
  assign acc1      = req1_valid & req1_ready;
  assign div_issue = acc0 | acc1;
  assign acc_id    = acc1;

  // NOTE: every signal gets a default at the top of always_comb, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    div_execution_vector = '0;
    div_vs2              = '0;
    div_vs1              = '0;
    if (acc0) begin
      div_execution_vector = req0_execution_vector;
      div_vs2              = req0_vs2;
      div_vs1              = req0_vs1;
    end else if (acc1) begin
      div_execution_vector = req1_execution_vector;
      div_vs2              = req1_vs2;
      div_vs1              = req1_vs1;
    end
  end

  // Outputs are forced to zero during reset so buffered data never leaks out.
  assign rsp_valid = ~reset & ~fifo_empty;
  assign rsp_id    = rsp_valid & mem_id[rd_ptr];
  assign rsp_vd    = rsp_valid ? mem_vd[rd_ptr] : '0;
  assign busy      = ~reset & ((|stage_valid) | ~fifo_empty);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    rst_q <= reset;
    if (reset) begin
      last_grant  <= 1'b1;  // favour req0 first
      stage_valid <= '0;
      stage_id    <= '0;
      credit_cnt  <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      stage_valid[0] <= div_issue;
      stage_id[0]    <= acc_id;
      for (int i = 1; i < DIV_LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_id[i]    <= stage_id[i-1];
      end

      if (div_issue) last_grant <= acc_id;

      // Moving from the last stage into the FIFO leaves the credit unchanged.
      credit_cnt <= credit_cnt + CNT_W'(div_issue) - CNT_W'(pop);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);

      // RSP_DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by fifo_count
  // and the outputs are masked by rsp_valid, so stale contents are never seen.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_vd[wr_ptr] <= div_vd;
      mem_id[wr_ptr] <= stage_id[DIV_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_vector_division_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vector_division_arbiter
//
// Directed and randomized stimulus for vector_division_arbiter. A datapath
// model returns lane-wise unsigned 32-bit quotients DIV_LATENCY cycles after
// issue. A scoreboard of accepted operations predicts responses, readiness,
// arbitration and busy.
// -----------------------------------------------------------------------------
module tb_vector_division_arbiter;
  import riscv_v_pkg::*;

  localparam int L     = 2;
  localparam int DEPTH = 4;
  localparam int LANES = VLEN / 32;

  logic              clock;
  logic              reset;
  logic              req0_valid, req0_ready;
  execution_vector_t req0_execution_vector;
  logic [VLEN-1:0]   req0_vs2, req0_vs1;
  logic              req1_valid, req1_ready;
  execution_vector_t req1_execution_vector;
  logic [VLEN-1:0]   req1_vs2, req1_vs1;
  logic              div_issue;
  execution_vector_t div_execution_vector;
  logic [VLEN-1:0]   div_vs2, div_vs1, div_vd;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [VLEN-1:0]   rsp_vd;
  logic              busy;

  vector_division_arbiter #(.DIV_LATENCY(L), .RSP_DEPTH(DEPTH)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .req0_valid            (req0_valid),
    .req0_ready            (req0_ready),
    .req0_execution_vector (req0_execution_vector),
    .req0_vs2              (req0_vs2),
    .req0_vs1              (req0_vs1),
    .req1_valid            (req1_valid),
    .req1_ready            (req1_ready),
    .req1_execution_vector (req1_execution_vector),
    .req1_vs2              (req1_vs2),
    .req1_vs1              (req1_vs1),
    .div_issue             (div_issue),
    .div_execution_vector  (div_execution_vector),
    .div_vs2               (div_vs2),
    .div_vs1               (div_vs1),
    .div_vd                (div_vd),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_id                (rsp_id),
    .rsp_vd                (rsp_vd),
    .busy                  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Lane-wise unsigned divide; divide by zero yields all ones.
  function automatic logic [VLEN-1:0] ref_div(input logic [VLEN-1:0] a,
                                              input logic [VLEN-1:0] b);
    logic [VLEN-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (b[i*32 +: 32] == 32'd0) r[i*32 +: 32] = 32'hFFFF_FFFF;
      else                        r[i*32 +: 32] = a[i*32 +: 32] / b[i*32 +: 32];
    end
    return r;
  endfunction

  // Datapath model: result appears L cycles after the issue cycle.
  logic [VLEN-1:0] dp [L];
  always @(posedge clock) begin
    dp[0] <= ref_div(div_vs2, div_vs1);
    for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
  end
  assign div_vd = dp[L-1];

  // Scoreboard
  typedef struct {
    logic            id;
    logic [VLEN-1:0] vd;
    int              acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_acc  = 0;
  int   n_rsp  = 0;
  logic prev_reset = 1'b1;
  logic last_id_m  = 1'b1;
  logic acc_ids[$];
  logic rsp_ids[$];
  int   rsp_cycles[$];

  task automatic check(input string tag, input logic [VLEN-1:0] obs,
                       input logic [VLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle against the model, then advances one clock.
  task automatic cycle();
    logic a0, a1, blk, cred;
    int   popn;
    #1;
    blk = reset | prev_reset;
    if (reset) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_vd", rsp_vd, 0);
      check("rst_busy", busy, 0);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_div_issue", div_issue, 0);
    end else begin
      check("busy", busy, sb.size() != 0);
      if (rsp_valid) begin
        if (sb.size() == 0) check("stale_rsp", rsp_valid, 0);
        else begin
          check("rsp_id", rsp_id, sb[0].id);
          check("rsp_vd", rsp_vd, sb[0].vd);
          check("rsp_latency", cyc >= sb[0].acc_cyc + L + 1, 1);
        end
      end
      popn = (rsp_valid && rsp_ready && sb.size() != 0) ? 1 : 0;
      cred = !blk && (sb.size() - popn < DEPTH);
      check("any_ready", req0_ready | req1_ready, cred);
      if (req0_valid && req1_valid) begin
        check("arb_req0_ready", req0_ready, cred & last_id_m);
        check("arb_req1_ready", req1_ready, cred & ~last_id_m);
      end else if (req0_valid) begin
        check("solo_req0_ready", req0_ready, cred);
      end else if (req1_valid) begin
        check("solo_req1_ready", req1_ready, cred);
      end
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      check("div_issue", div_issue, a0 | a1);
      if (a0 | a1) begin
        check("div_vs2", div_vs2, a1 ? req1_vs2 : req0_vs2);
        check("div_vs1", div_vs1, a1 ? req1_vs1 : req0_vs1);
        check("div_ev", div_execution_vector,
              a1 ? req1_execution_vector : req0_execution_vector);
        sb.push_back('{a1, a1 ? ref_div(req1_vs2, req1_vs1)
                              : ref_div(req0_vs2, req0_vs1), cyc});
        last_id_m = a1;
        n_acc++;
        acc_ids.push_back(a1);
      end else begin
        check("div_idle_zero", {div_vs2, div_vs1} == '0, 1);
      end
      if (popn != 0) begin
        void'(sb.pop_front());
        n_rsp++;
        rsp_cycles.push_back(cyc);
        rsp_ids.push_back(rsp_id);
      end
    end
    prev_reset = reset;
    @(posedge clock);
    #1;
    cyc++;
    if (prev_reset) begin
      sb.delete();
      last_id_m = 1'b1;
    end
  endtask

  function automatic logic [VLEN-1:0] rand_vec(input int unsigned hi);
    logic [VLEN-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*32 +: 32] = $urandom_range(hi, 0);
    return v;
  endfunction

  task automatic randomize_ops();
    req0_vs2 = rand_vec(32'hFFFF_FFFF);
    req0_vs1 = rand_vec(255);
    req1_vs2 = rand_vec(32'hFFFF_FFFF);
    req1_vs1 = rand_vec(255);
    req0_execution_vector = $bits(execution_vector_t)'($urandom());
    req1_execution_vector = $bits(execution_vector_t)'($urandom());
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();  // accepts are blocked in the first cycle after reset
  endtask

  initial begin
    int a_mark, r_mark, n0;
    logic [VLEN-1:0] exp_vd;

    reset      = 1'b1;
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    randomize_ops();

    // Reset state, including requests held valid through the blocked cycle.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("post_rst_no_accept", n_acc, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single op: 0x64 / 0x5 -> 0x14 in every lane, response at T+3.
    do_reset();
    rsp_ready = 1'b1;
    req0_vs2 = {LANES{32'h64}};
    req0_vs1 = {LANES{32'h5}};
    req0_valid = 1'b1;
    a_mark = n_acc;
    cycle();
    req0_valid = 1'b0;
    check("t035_accepted", n_acc - a_mark, 1);
    for (int k = 1; k <= 3; k++) begin
      check("t035_rsp_valid_timing", rsp_valid, k == 3);
      if (k == 3) begin
        check("t035_rsp_id", rsp_id, 0);
        check("t035_rsp_vd", rsp_vd, {LANES{32'h14}});
      end
      cycle();
    end

    // Contention: both valid for 4 cycles -> grants and responses 0,1,0,1.
    do_reset();
    rsp_ready = 1'b1;
    n0 = acc_ids.size();
    r_mark = rsp_ids.size();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      randomize_ops();
      cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (8) cycle();
    check("t036_n_acc", acc_ids.size() - n0, 4);
    check("t036_n_rsp", rsp_ids.size() - r_mark, 4);
    for (int k = 0; k < 4; k++) begin
      check("t036_grant_seq", acc_ids[n0+k], k[0]);
      check("t036_rsp_id_seq", rsp_ids[r_mark+k], k[0]);
    end

    // Backpressure: exactly RSP_DEPTH accepts, then one per response freed.
    do_reset();
    rsp_ready = 1'b0;
    randomize_ops();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    a_mark = n_acc;
    repeat (10) cycle();
    check("t037_accepts_full", n_acc - a_mark, DEPTH);
    #1;
    check("t037_req0_stalled", req0_ready, 0);
    check("t037_req1_stalled", req1_ready, 0);
    check("t037_rsp_pending", rsp_valid, 1);
    rsp_ready = 1'b1;
    a_mark = n_acc;
    cycle();
    rsp_ready = 1'b0;
    repeat (6) cycle();
    check("t037_one_more_accept", n_acc - a_mark, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) cycle();
    check("t037_drained", busy, 0);

    // Full-rate streaming on req1.
    do_reset();
    rsp_ready = 1'b1;
    req1_valid = 1'b1;
    a_mark = n_acc;
    r_mark = rsp_cycles.size();
    for (int k = 0; k < 10; k++) begin
      randomize_ops();
      cycle();
      check("t038_consecutive", n_acc - a_mark, k + 1);
    end
    req1_valid = 1'b0;
    repeat (15) cycle();
    check("t038_n_rsp", rsp_cycles.size() - r_mark, 10);
    check("t038_no_gap", rsp_cycles[r_mark+9] - rsp_cycles[r_mark], 9);

    // Reset mid-flight discards everything.
    do_reset();
    rsp_ready = 1'b1;
    a_mark = n_acc;
    randomize_ops();
    req0_valid = 1'b1;
    cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    cycle();
    req1_valid = 1'b0;
    check("t039_two_accepted", n_acc - a_mark, 2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t039_no_rsp", rsp_valid, 0);
      check("t039_not_busy", busy, 0);
      cycle();
    end

    // Hold stability under rsp_ready=0.
    do_reset();
    rsp_ready = 1'b0;
    randomize_ops();
    exp_vd = ref_div(req0_vs2, req0_vs1);
    req0_valid = 1'b1;
    cycle();
    req0_valid = 1'b0;
    for (int k = 0; k < 10 && !rsp_valid; k++) cycle();
    check("t040_rsp_arrived", rsp_valid, 1);
    for (int k = 0; k < 3; k++) begin
      check("t040_hold_vd", rsp_vd, exp_vd);
      check("t040_hold_id", rsp_id, 0);
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();

    // Randomized traffic against the scoreboard.
    do_reset();
    repeat (400) begin
      randomize_ops();
      req0_valid = 1'($urandom_range(1, 0));
      req1_valid = 1'($urandom_range(1, 0));
      rsp_ready  = ($urandom_range(9, 0) < 7);
      cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int k = 0; k < 40 && (sb.size() != 0 || busy); k++) cycle();
    check("rand_all_returned", sb.size(), 0);
    check("rand_final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_division_arbiter.md
VECTOR_DIVISION_ARBITER -- requirements
Module: vector_division_arbiter

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 2: fixed cycles from div_issue to valid div_vd; legal values 1..8.
REQ-002 SHALL have parameter RSP_DEPTH, default 4: response FIFO entries, a power of two, at least 2.
REQ-003 SHALL use VLEN and execution_vector_t from dragonfang_pkg/riscv_v_pkg.
REQ-004 Port: clock  in  1  single clock, all logic on posedge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: req0_valid  in  1  requester 0 has an operation.
REQ-007 Port: req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-008 Port: req0_execution_vector  in  execution_vector_t  requester 0 control.
REQ-009 Port: req0_vs2 / req0_vs1  in  VLEN each  requester 0 dividend/divisor.
REQ-010 Port: req1_valid, req1_ready, req1_execution_vector, req1_vs2, req1_vs1  as REQ-006..009 for requester 1.
REQ-011 Port: div_issue  out  1  operation presented to division datapath this cycle.
REQ-012 Port: div_execution_vector  out  execution_vector_t; div_vs2, div_vs1  out  VLEN  datapath operands.
REQ-013 Port: div_vd  in  VLEN  datapath result, valid DIV_LATENCY cycles after div_issue.
REQ-014 Port: rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-015 Port: rsp_id  out  1  originating requester; rsp_vd  out  VLEN  result.
REQ-016 Port: busy  out  1  any operation in flight or response held.

Function
REQ-017 Transfer on reqN: reqN_valid & reqN_ready; response transfer: rsp_valid & rsp_ready.
REQ-018 At most one request accepted per cycle; div_issue equals req0 transfer OR req1 transfer.
REQ-019 Credit rule: accept only if (in-flight count + FIFO occupancy) < RSP_DEPTH; an entry leaving the FIFO in the same cycle does not count toward this limit.
REQ-020 Arbitration: only one valid -> that requester granted; both valid -> requester not served last granted (round-robin).
REQ-021 reqN_ready: granted AND credit available; reqN_ready does not depend on reqN_valid of the same requester.
REQ-022 Round-robin pointer updates only on an accepted transfer; a grant without acceptance leaves it unchanged.
REQ-023 div_execution_vector/div_vs2/div_vs1 driven combinationally from the accepted requester when div_issue=1, all-zero otherwise.
REQ-024 In-flight tracking: DIV_LATENCY-stage shift register of {valid, id}; stage 0 loaded with {div_issue, accepted id}.
REQ-025 When the last stage is valid, div_vd and id are written into the FIFO at that clock edge; the FIFO never overflows (guaranteed by REQ-019).
REQ-026 Latency: request accepted in cycle T -> rsp_valid=1 no earlier than cycle T+DIV_LATENCY+1, and exactly then if the FIFO was empty.
REQ-027 rsp_valid = FIFO not empty; rsp_id/rsp_vd = FIFO head; stable while rsp_valid=1 and rsp_ready=0.
REQ-028 Responses are returned in acceptance order, regardless of requester.
REQ-029 FIFO push and pop in the same cycle: occupancy unchanged, head advances, both entries correct.
REQ-030 Pointers wrap modulo RSP_DEPTH; full/empty distinguished by an occupancy counter of $clog2(RSP_DEPTH)+1 bits.
REQ-031 busy = any in-flight stage valid OR FIFO not empty.

Reset
REQ-032 reset=1 at a clock edge: FIFO empty, all in-flight stages invalid, round-robin pointer favouring req0, credit count zero.
REQ-033 During reset and the first cycle after: rsp_valid=0, req0_ready=req1_ready=0 while reset=1, div_issue=0, busy=0, rsp_id=0, rsp_vd=0.
REQ-034 Reset mid-operation discards all in-flight and buffered results; no stale response appears after reset.

Verification
REQ-035 Single op: req0 vs2=0x64 lanes, vs1=0x5, datapath model returns 0x14 -> rsp_valid at T+3 (DIV_LATENCY=2), rsp_id=0, rsp_vd=0x14 lanes.
REQ-036 Contention: req0 and req1 valid for 4 cycles -> grants 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-037 Backpressure: rsp_ready=0, both requesters always valid -> exactly 4 accepts, then both ready=0; one rsp transfer -> exactly one further accept.
REQ-038 Full-rate streaming: rsp_ready=1, req1 only, 10 ops -> 10 consecutive accepts, 10 responses in order, no gap after the first.
REQ-039 Reset mid-flight: 2 ops accepted, reset pulsed at T+1 -> no rsp_valid for 5 cycles after reset, busy=0.
REQ-040 Hold stability: rsp_ready=0 for 3 cycles with rsp_valid=1 -> rsp_vd/rsp_id unchanged across those cycles.
